// File: rtl/dual_port_ram_be_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: clear FSM encoding
// and lane-count derivation.
package dual_port_ram_be_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    function automatic int unsigned num_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/dual_port_ram_be_lattice.sv
// Simple dual-port block RAM primitive: registered read, returns old data
// when a read and a write hit the same address in the same cycle.
module dual_port_ram_lattice #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  wclk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rclk,
    input  logic                  rst,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wclk) begin
        if (write_en) begin
            mem[waddr] <= din;
        end
    end

    // Output register has its own reset so the read port is never X after reset.
    always_ff @(posedge rclk) begin
        if (rst) begin
            dout <= '0;
        end else if (read_en) begin
            dout <= mem[raddr];
        end
    end

endmodule

// File: rtl/dual_port_ram_be.sv
// Byte-enable simple dual-port RAM with zero-fill sequencer, optional
// write-to-read forwarding and 1- or 2-cycle read latency.
module dual_port_ram_be
    import dual_port_ram_be_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BYPASS       = 1,
    localparam int unsigned NUM_BYTES   = num_bytes(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [NUM_BYTES-1:0]  byte_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_valid
);

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clearing, ready;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH-1:0] mem_waddr;

    logic                  v1_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [NUM_BYTES-1:0]  be_q;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] merged;

    assign clearing  = (state_q == CLEAR);
    assign ready     = (state_q == READY);
    assign init_done = ready;
    assign wr_acc    = ready & write_en;
    assign rd_acc    = ready & read_en & ~clear_req;
    assign mem_waddr = clearing ? cnt_q : waddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Collision info travels with the read so the merge lines up with the RAM output.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            hit_q <= 1'b0;
            din_q <= '0;
            be_q  <= '0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                hit_q <= wr_acc && (waddr == raddr);
                din_q <= din;
                be_q  <= byte_en;
            end
        end
    end

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        dual_port_ram_lattice #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (8)
        ) u_lane (
            .wclk     (clk),
            .write_en (clearing | (wr_acc & byte_en[i])),
            .waddr    (mem_waddr),
            .din      (clearing ? 8'h00 : din[8*i +: 8]),
            .rclk     (clk),
            .rst      (reset),
            .read_en  (rd_acc),
            .raddr    (raddr),
            .dout     (ram_q[8*i +: 8])
        );

        assign merged[8*i +: 8] = ((BYPASS != 0) && hit_q && be_q[i]) ? din_q[8*i +: 8]
                                                                      : ram_q[8*i +: 8];
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  vld_q;
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  adv;

        assign adv = v1_q & ready & ~clear_req;

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q  <= 1'b0;
                dout_q <= '0;
            end else begin
                vld_q <= adv;
                if (adv) begin
                    dout_q <= merged;
                end
            end
        end

        assign dout     = dout_q;
        assign rd_valid = vld_q;
    end else begin : g_lat1
        assign dout     = merged;
        assign rd_valid = v1_q;
    end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench: two instances (latency 1 + bypass, latency 2 + no bypass)
// driven with the same stimulus and checked against hand-computed values.
module tb_dual_port_ram_be;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic [3:0]  waddr;
    logic [31:0] din;
    logic [3:0]  byte_en;
    logic        write_en;
    logic [3:0]  raddr;
    logic        read_en;

    logic        init_done_a, rd_valid_a;
    logic [31:0] dout_a;
    logic        init_done_b, rd_valid_b;
    logic [31:0] dout_b;

    int n_cmp = 0;
    int n_err = 0;

    dual_port_ram_be #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (32),
        .READ_LATENCY (1),
        .BYPASS       (1)
    ) dut_a (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .init_done (init_done_a),
        .waddr     (waddr),
        .din       (din),
        .byte_en   (byte_en),
        .write_en  (write_en),
        .raddr     (raddr),
        .read_en   (read_en),
        .dout      (dout_a),
        .rd_valid  (rd_valid_a)
    );

    dual_port_ram_be #(
        .ADDR_WIDTH   (4),
        .DATA_WIDTH   (32),
        .READ_LATENCY (2),
        .BYPASS       (0)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .init_done (init_done_b),
        .waddr     (waddr),
        .din       (din),
        .byte_en   (byte_en),
        .write_en  (write_en),
        .raddr     (raddr),
        .read_en   (read_en),
        .dout      (dout_b),
        .rd_valid  (rd_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        waddr    = a;
        din      = d;
        byte_en  = be;
        write_en = 1'b1;
        step();
        write_en = 1'b0;
    endtask

    task automatic read_chk(input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb,
                            input string tag);
        raddr   = a;
        read_en = 1'b1;
        step();
        read_en = 1'b0;
        chk({tag, "/a_vld1"}, {31'b0, rd_valid_a}, 32'd1);
        chk({tag, "/a_dout"}, dout_a, ea);
        chk({tag, "/b_vld1"}, {31'b0, rd_valid_b}, 32'd0);
        step();
        chk({tag, "/a_vld2"}, {31'b0, rd_valid_a}, 32'd0);
        chk({tag, "/b_vld2"}, {31'b0, rd_valid_b}, 32'd1);
        chk({tag, "/b_dout"}, dout_b, eb);
    endtask

    initial begin
        reset     = 1'b1;
        clear_req = 1'b0;
        waddr     = '0;
        din       = '0;
        byte_en   = '0;
        write_en  = 1'b0;
        raddr     = '0;
        read_en   = 1'b0;

        // reset state
        step();
        step();
        chk("rst/a_init", {31'b0, init_done_a}, 32'd0);
        chk("rst/b_init", {31'b0, init_done_b}, 32'd0);
        chk("rst/a_vld",  {31'b0, rd_valid_a},  32'd0);
        chk("rst/b_vld",  {31'b0, rd_valid_b},  32'd0);
        chk("rst/a_dout", dout_a, 32'h0);
        chk("rst/b_dout", dout_b, 32'h0);
        reset = 1'b0;

        // zero-fill takes exactly DEPTH=16 cycles
        repeat (15) step();
        chk("clr15/a_init", {31'b0, init_done_a}, 32'd0);
        chk("clr15/b_init", {31'b0, init_done_b}, 32'd0);
        step();
        chk("clr16/a_init", {31'b0, init_done_a}, 32'd1);
        chk("clr16/b_init", {31'b0, init_done_b}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            read_chk(4'(i), 32'h0, 32'h0, $sformatf("zero%0d", i));
        end

        // byte-lane write, then a write with no lanes enabled
        wr(4'd3, 32'hAABBCCDD, 4'b0101);
        read_chk(4'd3, 32'h00BB00DD, 32'h00BB00DD, "be0101");
        wr(4'd3, 32'hFFFFFFFF, 4'b0000);
        read_chk(4'd3, 32'h00BB00DD, 32'h00BB00DD, "be0000");

        // same-cycle collision
        wr(4'd5, 32'hFFFFFFFF, 4'b1111);
        waddr    = 4'd5;
        din      = 32'h11223344;
        byte_en  = 4'b1111;
        write_en = 1'b1;
        raddr    = 4'd5;
        read_en  = 1'b1;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        chk("coll/a_vld",  {31'b0, rd_valid_a}, 32'd1);
        chk("coll/a_dout", dout_a, 32'h11223344);
        step();
        chk("coll/b_vld",  {31'b0, rd_valid_b}, 32'd1);
        chk("coll/b_dout", dout_b, 32'hFFFFFFFF);
        read_chk(4'd5, 32'h11223344, 32'h11223344, "coll_after");

        // partial-lane collision: bypass merges only enabled lanes
        waddr    = 4'd5;
        din      = 32'hA0B0C0D0;
        byte_en  = 4'b1001;
        write_en = 1'b1;
        raddr    = 4'd5;
        read_en  = 1'b1;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        chk("pcoll/a_dout", dout_a, 32'hA02233D0);
        step();
        chk("pcoll/b_dout", dout_b, 32'h11223344);
        read_chk(4'd5, 32'hA02233D0, 32'hA02233D0, "pcoll_after");

        // back-to-back reads
        for (int i = 0; i < 8; i++) begin
            wr(4'(i), 32'(i), 4'b1111);
        end
        for (int i = 0; i < 10; i++) begin
            raddr   = 4'(i);
            read_en = (i < 8);
            step();
            chk($sformatf("b2b%0d/a_vld", i), {31'b0, rd_valid_a}, (i < 8) ? 32'd1 : 32'd0);
            if (i < 8) chk($sformatf("b2b%0d/a_dout", i), dout_a, 32'(i));
            chk($sformatf("b2b%0d/b_vld", i), {31'b0, rd_valid_b},
                (i >= 1 && i <= 8) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 8) chk($sformatf("b2b%0d/b_dout", i), dout_b, 32'(i - 1));
        end
        read_en = 1'b0;

        // clear_req with a latency-2 read in flight
        raddr   = 4'd3;
        read_en = 1'b1;
        step();
        read_en   = 1'b0;
        clear_req = 1'b1;
        chk("abort/a_vld",  {31'b0, rd_valid_a}, 32'd1);
        chk("abort/a_dout", dout_a, 32'd3);
        step();
        clear_req = 1'b0;
        chk("abort/b_vld",  {31'b0, rd_valid_b}, 32'd0);
        chk("abort/b_hold", dout_b, 32'd7);
        chk("abort/a_vld0", {31'b0, rd_valid_a}, 32'd0);
        chk("abort/a_init", {31'b0, init_done_a}, 32'd0);
        chk("abort/b_init", {31'b0, init_done_b}, 32'd0);
        repeat (15) step();
        chk("reclr15/a_init", {31'b0, init_done_a}, 32'd0);
        step();
        chk("reclr16/a_init", {31'b0, init_done_a}, 32'd1);
        chk("reclr16/b_init", {31'b0, init_done_b}, 32'd1);
        read_chk(4'd3, 32'h0, 32'h0, "reclr_addr3");

        // strobes during CLEAR are ignored
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("ign/a_init", {31'b0, init_done_a}, 32'd0);
        repeat (12) step();
        waddr    = 4'd2;
        din      = 32'hDEADBEEF;
        byte_en  = 4'b1111;
        write_en = 1'b1;
        raddr    = 4'd2;
        read_en  = 1'b1;
        step();
        write_en = 1'b0;
        read_en  = 1'b0;
        chk("ign/a_vld1", {31'b0, rd_valid_a}, 32'd0);
        chk("ign/b_vld1", {31'b0, rd_valid_b}, 32'd0);
        step();
        chk("ign/a_vld2", {31'b0, rd_valid_a}, 32'd0);
        chk("ign/b_vld2", {31'b0, rd_valid_b}, 32'd0);
        for (int k = 0; k < 40 && !init_done_a; k++) step();
        chk("ign/a_done", {31'b0, init_done_a}, 32'd1);
        chk("ign/b_done", {31'b0, init_done_b}, 32'd1);
        read_chk(4'd2, 32'h0, 32'h0, "ign_addr2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Next-generation simple dual-port RAM: one write port, one read port, single clock. Adds byte-lane write enables, selectable read latency (1 or 2), optional same-cycle write-to-read forwarding, read-valid tracking and a hardware zero-fill sequencer run after reset or on request. Used for MCU data memory and peripheral buffers wherever byte stores and known-clean contents are required.

Parameters:
ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH words.
DATA_WIDTH, 32, word width; must be a multiple of 8; NUM_BYTES = DATA_WIDTH/8.
READ_LATENCY, 1, cycles from accepted read_en to rd_valid; legal values are 1 or 2.
BYPASS, 1, 1 = same-cycle same-address read returns newly written bytes; 0 = returns old data.

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
clear_req  in  1  pulse: restart zero-fill (ignored while already clearing)
init_done  out  1  high when memory is cleared and ports are live
waddr  in  ADDR_WIDTH  write word address
din  in  DATA_WIDTH  write data
byte_en  in  NUM_BYTES  per-byte write enable, bit i covers din[8i+7:8i]
write_en  in  1  write strobe
raddr  in  ADDR_WIDTH  read word address
read_en  in  1  read strobe
dout  out  DATA_WIDTH  read data, valid when rd_valid=1
rd_valid  out  1  read data qualifier

Behaviour:
- Reset values: init_done=0, rd_valid=0, dout=0, FSM=CLEAR, clear counter=0, latency pipeline cleared.
- FSM states: CLEAR and READY.
- CLEAR: writes all-zero, all byte lanes, to address = counter; increments counter by 1 per cycle. External write_en and read_en are ignored, and init_done=0. When the counter reaches DEPTH-1, that write completes, the FSM enters READY the next cycle, and init_done rises. Full clear takes exactly DEPTH cycles after reset deasserts.
- READY: init_done=1. clear_req=1 resets the counter to 0, enters CLEAR and drops init_done the next cycle. Any in-flight read is discarded; rd_valid is forced to 0.
- Reset asserted mid-clear or mid-read: returns to reset values and restarts the clear from address 0.
- Write: write_en=1 in READY updates only bytes with byte_en[i]=1. byte_en=0 with write_en=1 is a no-op. The write is visible to any read issued on a later cycle.
- Read: read_en=1 in READY samples raddr. READ_LATENCY=1 gives rd_valid and dout on the next edge. READ_LATENCY=2 adds one output register stage. Back-to-back reads are accepted every cycle at full throughput.
- dout holds its last value while rd_valid=0 and never returns to X after reset.
- Collision (read_en & write_en & raddr==waddr, same cycle):
  - BYPASS=1: returned word has din bytes where byte_en=1 and old memory bytes elsewhere.
  - BYPASS=0: returns old word.
  - Memory is updated in both cases.
- Forwarding implementation: register a hit flag, din and byte_en alongside the read; merge per byte at the storage output. The primitive itself returns old data on collision.
- No read/write address range checks are needed: addresses wrap naturally within ADDR_WIDTH.

Decomposition:
- Shared package: clear FSM state encoding (CLEAR/READY) and a NUM_BYTES derivation constant/function.
- Sub-module: storage is one dual_port_ram_lattice instance per byte lane (DATA_WIDTH 8, wclk=rclk=clk), so byte enables map to per-lane write_en.
- The wrapper owns the FSM, clear mux, forwarding merge and latency pipeline.

Test Plan:
1. Reset 2 cycles, ADDR_WIDTH=4 -> init_done rises exactly 16 cycles after reset falls. Every address then reads 0x00000000.
2. Write 0xAABBCCDD to addr 3 with byte_en=4'b0101, then read addr 3 -> dout=0x00BB00DD. rd_valid is high for 1 cycle at READ_LATENCY cycles after read_en (test both latencies).
3. Same-cycle write 0x11223344 (byte_en=4'b1111) and read, both at addr 5 holding 0xFFFFFFFF -> BYPASS=1 returns 0x11223344; BYPASS=0 returns 0xFFFFFFFF. Next read returns 0x11223344 in both cases.
4. Continuous read_en for 8 cycles, addresses 0..7 preloaded with their index -> 8 consecutive rd_valid cycles, dout=0..7 in order.
5. clear_req while a READ_LATENCY=2 read is in flight -> rd_valid stays 0 and init_done drops. After DEPTH cycles, previously written addr 3 reads 0.
6. write_en/read_en pulsed during CLEAR -> no rd_valid. After clear completes, the targeted address still reads 0.
